// File: rtl/calc_exec_unit.sv
// calc_exec_unit -- operand/operator capture plus an add/sub/mult execution unit.
// Operands and operator are captured from switch/button inputs according to the
// externally supplied opcode-FSM state. Add and sub complete in one cycle. Mult
// is an 8-cycle shift-add by default. Defining CALC_EXEC_FAST_MULT_EN replaces it
// with a single-cycle combinational multiply.
module calc_exec_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  state_q,
  input  logic        enter,
  input  logic        add,
  input  logic        sub,
  input  logic        mult,
  input  logic [7:0]  sw_in,
  output logic [15:0] result,
  output logic        busy,
  output logic        done,
  output logic        neg
);

  // Opcode-FSM state codes (driven from outside)
  localparam logic [2:0] ST_CLR = 3'd0;
  localparam logic [2:0] ST_A   = 3'd1;
  localparam logic [2:0] ST_OP  = 3'd3;
  localparam logic [2:0] ST_B   = 3'd7;

  // Operator encodings
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MULT = 2'b11;

  // Execution FSM states
  localparam logic [1:0] EX_IDLE = 2'd0;
  localparam logic [1:0] EX_MUL  = 2'd1;
  localparam logic [1:0] EX_DONE = 2'd2;

  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] result_q, result_d;
  logic        neg_q, neg_d;
  logic [1:0]  ex_q, ex_d;

`ifndef CALC_EXEC_FAST_MULT_EN
  logic [7:0]  mcand_q, mcand_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] acc_step;
`endif

  logic load_b;
  logic start;

  assign busy   = (ex_q == EX_MUL);
  assign done   = (ex_q == EX_DONE);
  assign result = result_q;
  assign neg    = neg_q;

  assign load_b = enter && (state_q == ST_B) && !busy;
  assign start  = load_b && (op_q != OP_NONE);

`ifndef CALC_EXEC_FAST_MULT_EN
  // Partial-product accumulation for the current multiplier bit
  always_comb begin
    acc_step = acc_q;
    if (b_q[cnt_q]) begin
      acc_step = acc_q + ({8'd0, mcand_q} << cnt_q);
    end
  end
`endif

  // Next-state logic for capture registers and the execution FSM
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    neg_d    = neg_q;
    ex_d     = ex_q;
`ifndef CALC_EXEC_FAST_MULT_EN
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif

    if (state_q == ST_CLR) begin
      a_d      = '0;
      b_d      = '0;
      op_d     = OP_NONE;
      result_d = '0;
      neg_d    = 1'b0;
      ex_d     = EX_IDLE;
`ifndef CALC_EXEC_FAST_MULT_EN
      mcand_d  = '0;
      acc_d    = '0;
      cnt_d    = '0;
`endif
    end else begin
      if (enter && (state_q == ST_A)) begin
        a_d = sw_in;
      end

      if ((state_q == ST_OP) && (add || sub || mult)) begin
        if (mult)     op_d = OP_MULT;
        else if (sub) op_d = OP_SUB;
        else          op_d = OP_ADD;
      end

      if (load_b) begin
        b_d = sw_in;
      end

      if (ex_q == EX_MUL) begin
`ifndef CALC_EXEC_FAST_MULT_EN
        if (cnt_q == 3'd7) begin
          result_d = acc_step;
          neg_d    = 1'b0;
          ex_d     = EX_DONE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 3'd1;
        end
`else
        ex_d = EX_IDLE;
`endif
      end else if (start) begin
        // Start is honoured from IDLE and from DONE (busy is low in both);
        // B is taken straight from sw_in since b_q only updates on this edge.
        case (op_q)
          OP_ADD: begin
            result_d = {8'd0, a_q} + {8'd0, sw_in};
            neg_d    = 1'b0;
            ex_d     = EX_DONE;
          end
          OP_SUB: begin
            result_d = {8'd0, a_q} - {8'd0, sw_in};
            neg_d    = (a_q < sw_in);
            ex_d     = EX_DONE;
          end
          default: begin
`ifdef CALC_EXEC_FAST_MULT_EN
            result_d = {8'd0, a_q} * {8'd0, sw_in};
            neg_d    = 1'b0;
            ex_d     = EX_DONE;
`else
            mcand_d  = a_q;
            acc_d    = '0;
            cnt_d    = '0;
            ex_d     = EX_MUL;
`endif
          end
        endcase
      end else if (ex_q == EX_DONE) begin
        ex_d = EX_IDLE;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_NONE;
      result_q <= '0;
      neg_q    <= 1'b0;
      ex_q     <= EX_IDLE;
`ifndef CALC_EXEC_FAST_MULT_EN
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      ex_q     <= ex_d;
`ifndef CALC_EXEC_FAST_MULT_EN
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_calc_exec_unit.sv
// Self-checking bench for calc_exec_unit; honours CALC_EXEC_FAST_MULT_EN.
module tb_calc_exec_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  state_q = 3'd0;
  logic        enter = 1'b0;
  logic        add = 1'b0;
  logic        sub = 1'b0;
  logic        mult = 1'b0;
  logic [7:0]  sw_in = 8'd0;
  logic [15:0] result;
  logic        busy;
  logic        done;
  logic        neg;

  int total = 0;
  int bad = 0;

`ifdef CALC_EXEC_FAST_MULT_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 9;
  localparam int MUL_BUSY = 8;
`endif

  calc_exec_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .state_q (state_q),
    .enter   (enter),
    .add     (add),
    .sub     (sub),
    .mult    (mult),
    .sw_in   (sw_in),
    .result  (result),
    .busy    (busy),
    .done    (done),
    .neg     (neg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ops: bit2 mult, bit1 sub, bit0 add. Returns right after the start edge.
  task automatic do_op(input bit load_a, input logic [7:0] a, input logic [2:0] ops,
                       input logic [7:0] b);
    if (load_a) begin
      state_q = 3'd1; enter = 1'b1; sw_in = a;
      tick();
      enter = 1'b0;
    end
    state_q = 3'd3; mult = ops[2]; sub = ops[1]; add = ops[0];
    tick();
    mult = 1'b0; sub = 1'b0; add = 1'b0;
    state_q = 3'd7; enter = 1'b1; sw_in = b;
    tick();
    enter = 1'b0;
  endtask

  // Runs an op and reports observations; comparisons are done by the callers.
  task automatic run_op(input logic [7:0] a, input logic [2:0] ops, input logic [7:0] b,
                        output int lat, output int bc, output logic [15:0] res,
                        output logic ng, output logic done_after, output logic [15:0] res_hold);
    lat = 0; bc = 0;
    do_op(1'b1, a, ops, b);
    for (int i = 1; i <= 20; i++) begin
      if (done) begin lat = i; break; end
      if (busy) bc++;
      tick();
    end
    res = result; ng = neg;
    tick();
    done_after = done; res_hold = result;
  endtask

  function automatic logic [16:0] model(input logic [7:0] a, input logic [2:0] ops,
                                        input logic [7:0] b);
    int r;
    logic n;
    n = 1'b0;
    if (ops[2])      r = int'(a) * int'(b);
    else if (ops[1]) begin r = int'(a) - int'(b); n = (a < b); end
    else             r = int'(a) + int'(b);
    return {n, r[15:0]};
  endfunction

  task automatic test_reset();
    #2;
    total++;
    if ({result, busy, done, neg} !== 19'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {result, busy, done, neg});
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    total++;
    if ({result, busy, done, neg} !== 19'd0) begin
      bad++; $display("FAIL post_reset_outputs got=%h want=0", {result, busy, done, neg});
    end
  endtask

  task automatic test_add();
    int lat, bc; logic [15:0] res, hold; logic ng, da;
    run_op(8'd25, 3'b001, 8'd17, lat, bc, res, ng, da, hold);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
    total++;
    if (res !== 16'd42 || ng !== 1'b0) begin
      bad++; $display("FAIL add_25_17 got=%0d neg=%b want=42 neg=0", res, ng);
    end
    total++;
    if (da !== 1'b0 || hold !== 16'd42) begin
      bad++; $display("FAIL add_done_pulse done=%b res=%0d want done=0 res=42", da, hold);
    end
  endtask

  task automatic test_sub();
    int lat, bc; logic [15:0] res, hold; logic ng, da;
    state_q = 3'd0; tick();
    run_op(8'd5, 3'b010, 8'd9, lat, bc, res, ng, da, hold);
    total++;
    if (res !== 16'hFFFC || ng !== 1'b1 || lat !== 1) begin
      bad++; $display("FAIL sub_5_9 got=%h neg=%b lat=%0d want=fffc neg=1 lat=1", res, ng, lat);
    end
    total++;
    if (hold !== 16'hFFFC || da !== 1'b0) begin
      bad++; $display("FAIL sub_hold got=%h done=%b want=fffc done=0", hold, da);
    end
    run_op(8'd9, 3'b010, 8'd5, lat, bc, res, ng, da, hold);
    total++;
    if (res !== 16'd4 || ng !== 1'b0) begin
      bad++; $display("FAIL sub_9_5 got=%0d neg=%b want=4 neg=0", res, ng);
    end
  endtask

  task automatic test_mult();
    int lat, bc; logic [15:0] res, hold; logic ng, da;
    run_op(8'd5, 3'b010, 8'd9, lat, bc, res, ng, da, hold);   // leave neg=1
    run_op(8'd255, 3'b100, 8'd255, lat, bc, res, ng, da, hold);
    total++;
    if (bc !== MUL_BUSY || lat !== MUL_LAT) begin
      bad++; $display("FAIL mult_timing busy=%0d lat=%0d want busy=%0d lat=%0d",
                      bc, lat, MUL_BUSY, MUL_LAT);
    end
    total++;
    if (res !== 16'hFE01 || ng !== 1'b0) begin
      bad++; $display("FAIL mult_255_255 got=%h neg=%b want=fe01 neg=0", res, ng);
    end
    total++;
    if (da !== 1'b0 || hold !== 16'hFE01) begin
      bad++; $display("FAIL mult_done_pulse done=%b res=%h", da, hold);
    end
  endtask

  task automatic test_priority();
    int lat, bc; logic [15:0] res, hold; logic ng, da;
    run_op(8'd12, 3'b101, 8'd11, lat, bc, res, ng, da, hold);
    total++;
    if (res !== 16'd132 || lat !== MUL_LAT) begin
      bad++; $display("FAIL prio_add_mult got=%0d lat=%0d want=132 lat=%0d", res, lat, MUL_LAT);
    end
    run_op(8'd12, 3'b011, 8'd20, lat, bc, res, ng, da, hold);
    total++;
    if (res !== 16'hFFF8 || ng !== 1'b1) begin
      bad++; $display("FAIL prio_add_sub got=%h neg=%b want=fff8 neg=1", res, ng);
    end
  endtask

  task automatic test_random();
    int lat, bc; logic [15:0] res, hold; logic ng, da;
    logic [7:0] a, b; logic [2:0] ops; logic [16:0] exp;
    for (int k = 0; k < 12; k++) begin
      a = 8'($urandom); b = 8'($urandom);
      ops = 3'($urandom_range(1, 7));
      exp = model(a, ops, b);
      run_op(a, ops, b, lat, bc, res, ng, da, hold);
      total++;
      if (res !== exp[15:0] || ng !== exp[16] || lat !== (ops[2] ? MUL_LAT : 1)) begin
        bad++; $display("FAIL random a=%0d b=%0d ops=%b got=%h neg=%b lat=%0d want=%h neg=%b",
                        a, b, ops, res, ng, lat, exp[15:0], exp[16]);
      end
    end
  endtask

  task automatic test_busy_enter();
    int lat, bc; logic [15:0] res, hold; logic ng, da;
    bit seen;
    run_op(8'd1, 3'b001, 8'd1, lat, bc, res, ng, da, hold);
    do_op(1'b1, 8'd10, 3'b100, 8'd20);
    seen = 1'b0;
    // enter in state 7 while busy, A reload and operator change mid-operation
    state_q = 3'd7; enter = 1'b1; sw_in = 8'd99;
    if (done) seen = 1'b1;
    tick();
    enter = 1'b0;
    state_q = 3'd1; enter = 1'b1; sw_in = 8'd77;
    if (done) seen = 1'b1;
    tick();
    enter = 1'b0;
    state_q = 3'd3; add = 1'b1;
    if (done) seen = 1'b1;
    tick();
    add = 1'b0;
    state_q = 3'd2; enter = 1'b1; sw_in = 8'd3;   // enter in an unused state
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    enter = 1'b0;
    total++;
    if (!seen || result !== 16'd200) begin
      bad++; $display("FAIL busy_enter_mult seen=%b got=%0d want=200", seen, result);
    end
    tick();
    total++;
    if (done !== 1'b0 || result !== 16'd200) begin
      bad++; $display("FAIL busy_enter_ignored done=%b got=%0d want done=0 res=200", done, result);
    end
    do_op(1'b0, 8'd0, 3'b010, 8'd7);
    total++;
    if (done !== 1'b1 || result !== 16'd70) begin
      bad++; $display("FAIL a_loaded_during_mul done=%b got=%0d want=70", done, result);
    end
    tick();
  endtask

  task automatic test_clear_mid_mul();
    int lat, bc; logic [15:0] res, hold; logic ng, da;
    bit seen;
    run_op(8'd5, 3'b010, 8'd9, lat, bc, res, ng, da, hold);
    do_op(1'b1, 8'd200, 3'b100, 8'd3);
    tick();
    state_q = 3'd0;
    tick();
    total++;
    if (result !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || neg !== 1'b0) begin
      bad++; $display("FAIL clear_mid_mul res=%h busy=%b done=%b neg=%b want all 0",
                      result, busy, done, neg);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) seen = 1'b1;
      tick();
    end
    total++;
    if (seen) begin bad++; $display("FAIL clear_no_done got=activity want=none"); end
    // operator register was cleared: a start attempt must be ignored
    do_op(1'b1, 8'd9, 3'b000, 8'd4);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) seen = 1'b1;
      tick();
    end
    total++;
    if (seen || result !== 16'd0) begin
      bad++; $display("FAIL no_op_start seen=%b got=%0d want none res=0", seen, result);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat, bc; logic [15:0] res, hold; logic ng, da;
    bit seen;
    run_op(8'd5, 3'b010, 8'd9, lat, bc, res, ng, da, hold);
    do_op(1'b1, 8'd100, 3'b100, 8'd100);
    tick(); tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (result !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || neg !== 1'b0) begin
      bad++; $display("FAIL reset_mid_mul res=%h busy=%b done=%b neg=%b want all 0",
                      result, busy, done, neg);
    end
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen = 1'b1;
      tick();
    end
    total++;
    if (seen) begin bad++; $display("FAIL reset_no_done got=activity want=none"); end
    run_op(8'd3, 3'b001, 8'd4, lat, bc, res, ng, da, hold);
    total++;
    if (res !== 16'd7 || lat !== 1 || ng !== 1'b0) begin
      bad++; $display("FAIL first_after_reset got=%0d lat=%0d want=7 lat=1", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mult();
    test_priority();
    test_random();
    test_busy_enter();
    test_clear_mid_mul();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
